// File: rtl/alu_mem_pkg.sv
// Shared types and constants for the ALU memory-bus master.
// Optional macro: ALU_BUS_MASTER_READBACK_EN adds the readback states.
package alu_mem_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_OP,
        WAIT,
        RESP
`ifdef ALU_BUS_MASTER_READBACK_EN
        ,
        RB_0,
        RB_1,
        RB_2,
        RB_CHK
`endif
    } state_t;

    // Register map of the ALU slave; address 3 is never used.
    localparam int unsigned ADDR_A  = 0;
    localparam int unsigned ADDR_B  = 1;
    localparam int unsigned ADDR_OP = 2;

endpackage

// File: rtl/alu_bus_master.sv
// Command-driven master for the ALU memory bus: writes operands and opcode,
// waits RES_LATENCY cycles, captures the result and hands it back.
// Optional macro: ALU_BUS_MASTER_READBACK_EN reads the three registers back
// after the wait and flags any mismatch on rsp_err.
module alu_bus_master
    import alu_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned RES_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DATA_WIDTH-1:0]     req_a,
    input  logic [DATA_WIDTH-1:0]     req_b,
    input  logic [DATA_WIDTH-1:0]     req_op,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      rd_wr,
    output logic                      enable,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    input  logic [2*DATA_WIDTH-1:0]   res_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [2*DATA_WIDTH-1:0]   rsp_data,
    output logic                      rsp_err
);

    localparam logic [3:0] CNT_LAST = 4'(RES_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, b_q, op_q;
    logic [3:0]              wait_cnt_q;
    logic [2*DATA_WIDTH-1:0] rsp_data_q;
    logic                    wait_done;

    assign wait_done = (wait_cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and bus drive; idle bus lines are held at zero.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        enable    = 1'b0;
        rd_wr     = 1'b0;
        addr      = '0;
        wr_data   = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = WR_A;
            end
            WR_A: begin
                enable  = 1'b1;
                addr    = ADDR_WIDTH'(ADDR_A);
                wr_data = a_q;
                state_d = WR_B;
            end
            WR_B: begin
                enable  = 1'b1;
                addr    = ADDR_WIDTH'(ADDR_B);
                wr_data = b_q;
                state_d = WR_OP;
            end
            WR_OP: begin
                enable  = 1'b1;
                addr    = ADDR_WIDTH'(ADDR_OP);
                wr_data = op_q;
                state_d = WAIT;
            end
            WAIT: begin
`ifdef ALU_BUS_MASTER_READBACK_EN
                if (wait_done) state_d = RB_0;
`else
                if (wait_done) state_d = RESP;
`endif
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
`ifdef ALU_BUS_MASTER_READBACK_EN
            RB_0: begin
                enable  = 1'b1;
                rd_wr   = 1'b1;
                addr    = ADDR_WIDTH'(ADDR_A);
                state_d = RB_1;
            end
            RB_1: begin
                enable  = 1'b1;
                rd_wr   = 1'b1;
                addr    = ADDR_WIDTH'(ADDR_B);
                state_d = RB_2;
            end
            RB_2: begin
                enable  = 1'b1;
                rd_wr   = 1'b1;
                addr    = ADDR_WIDTH'(ADDR_OP);
                state_d = RB_CHK;
            end
            RB_CHK: state_d = RESP;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, wait counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            wait_cnt_q <= '0;
            rsp_data_q <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                a_q  <= req_a;
                b_q  <= req_b;
                op_q <= req_op;
            end
            if (state_q == WAIT) begin
                if (wait_done) begin
                    rsp_data_q <= res_out;
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_q + 4'd1;
                end
            end
        end
    end

    assign rsp_data = rsp_data_q;

`ifdef ALU_BUS_MASTER_READBACK_EN
    logic [DATA_WIDTH-1:0] rb_a_q, rb_b_q;
    logic                  rsp_err_q;

    // Read data arrives one cycle after each read; the opcode readback is
    // compared straight off rd_data in RB_CHK.
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_a_q    <= '0;
            rb_b_q    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q == RB_1) rb_a_q <= rd_data;
            if (state_q == RB_2) rb_b_q <= rd_data;
            if (state_q == RB_CHK) begin
                rsp_err_q <= (rb_a_q != a_q) | (rb_b_q != b_q) | (rd_data != op_q);
            end
        end
    end

    assign rsp_err = rsp_err_q;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
    assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_bus_master.sv
// Self-checking bench for alu_bus_master with a small ALU slave model and
// scoreboards for bus writes and responses.
// Honours ALU_BUS_MASTER_READBACK_EN when the DUT is built with it.
module tb_alu_bus_master;

    localparam int AW  = 2;
    localparam int DW  = 8;
    localparam int LAT = 2;
`ifdef ALU_BUS_MASTER_READBACK_EN
    localparam int RB_EXTRA = 4;
`else
    localparam int RB_EXTRA = 0;
`endif
    localparam int EXP_LAT = 3 + LAT + RB_EXTRA;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [DW-1:0]   req_a, req_b, req_op;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wr_data;
    logic            rd_wr;
    logic            enable;
    logic [DW-1:0]   rd_data;
    logic [2*DW-1:0] res_out;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2*DW-1:0] rsp_data;
    logic            rsp_err;

    alu_bus_master #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .RES_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_wr     (rd_wr),
        .enable    (enable),
        .rd_data   (rd_data),
        .res_out   (res_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ALU result as the slave computes it from its registers.
    function automatic logic [2*DW-1:0] alu_res(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [DW-1:0] op);
        case (op)
            8'h00:   alu_res = 16'(a) + 16'(b);
            8'h01:   alu_res = 16'(a) - 16'(b);
            8'h02:   alu_res = 16'(a) * 16'(b);
            default: alu_res = {a, b};
        endcase
    endfunction

    // Slave: register file, registered read data, optional corrupted B readback.
    logic [DW-1:0] mem [0:3];
    logic          corrupt_b;

    always @(posedge clk) begin
        if (enable && !rd_wr) mem[addr] <= wr_data;
        if (enable && rd_wr)  rd_data <= (corrupt_b && addr == 2'd1) ? 8'hFF : mem[addr];
    end
    assign res_out = alu_res(mem[0], mem[1], mem[2]);

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct {
        logic [2*DW-1:0] data;
        logic            err;
    } rsp_t;

    wr_t  wr_q[$];
    rsp_t rsp_q[$];
    wr_t  mon_w;
    rsp_t mon_r;
    int   wr_seen  = 0;
    int   rsp_seen = 0;

    // Bus and response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (enable) check_eq("addr3_enable", 32'(addr == 2'd3), 32'd0);
            if (enable && !rd_wr) begin
                wr_seen++;
                check_eq("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    mon_w = wr_q.pop_front();
                    check_eq("wr_addr", 32'(addr), 32'(mon_w.addr));
                    check_eq("wr_data", 32'(wr_data), 32'(mon_w.data));
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                check_eq("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    mon_r = rsp_q.pop_front();
                    check_eq("rsp_data", 32'(rsp_data), 32'(mon_r.data));
                    check_eq("rsp_err", 32'(rsp_err), 32'(mon_r.err));
                end
            end
        end
    end

    task automatic push_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] op, input logic bad);
        wr_t  w;
        rsp_t r;
        w.addr = 2'd0; w.data = a;  wr_q.push_back(w);
        w.addr = 2'd1; w.data = b;  wr_q.push_back(w);
        w.addr = 2'd2; w.data = op; wr_q.push_back(w);
        r.data = alu_res(a, b, op);
`ifdef ALU_BUS_MASTER_READBACK_EN
        r.err = bad;
`else
        r.err = 1'b0 & bad;
`endif
        rsp_q.push_back(r);
    endtask

    // Drive a command and return #1 after the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] op, input logic bad);
        int n;
        push_cmd(a, b, op, bad);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        check_eq("accept_timeout", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Count rising edges from the current point until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!rsp_valid && lat < 200);
    endtask

    int lat;
    int snap;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        corrupt_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data",  32'(rsp_data),  32'd0);
        check_eq("rst_rsp_err",   32'(rsp_err),   32'd0);
        check_eq("rst_enable",    32'(enable),    32'd0);
        check_eq("rst_rd_wr",     32'(rd_wr),     32'd0);
        check_eq("rst_addr",      32'(addr),      32'd0);
        check_eq("rst_wr_data",   32'(wr_data),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);

        // Basic add with rsp_ready already high.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(8'h05, 8'h03, 8'h00, 1'b0);
        wait_rsp(lat);
        check_eq("basic_latency", 32'(lat), 32'(EXP_LAT));
        check_eq("basic_data", 32'(rsp_data), 32'h0008);
        @(posedge clk); #1;
        check_eq("basic_done_valid", 32'(rsp_valid), 32'd0);
        check_eq("basic_idle_ready", 32'(req_ready), 32'd1);

        // Back-pressure for ten cycles.
        rsp_ready = 1'b0;
        send(8'h40, 8'h11, 8'h01, 1'b0);
        wait_rsp(lat);
        check_eq("bp_latency", 32'(lat), 32'(EXP_LAT));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_valid_held", 32'(rsp_valid), 32'd1);
            check_eq("bp_data_held",  32'(rsp_data),  32'h002F);
            check_eq("bp_req_ready",  32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release", 32'(rsp_valid), 32'd0);

        // Second request raised during WR_B of the first.
        send(8'h07, 8'h06, 8'h02, 1'b0);
        @(posedge clk); #1;
        snap = rsp_seen;
        push_cmd(8'hA5, 8'h5A, 8'h03, 1'b0);
        req_a     = 8'hA5;
        req_b     = 8'h5A;
        req_op    = 8'h03;
        req_valid = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (req_ready) break;
            lat++;
        end
        check_eq("busy_accept_timeout", 32'(lat < 100), 32'd1);
        check_eq("busy_first_done", 32'(rsp_seen - snap), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(lat);
        check_eq("busy_latency", 32'(lat), 32'(EXP_LAT));
        check_eq("busy_data", 32'(rsp_data), 32'hA55A);
        @(posedge clk); #1;

        // Reset while WR_B is on the bus.
        send(8'h21, 8'h22, 8'h00, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_enable",    32'(enable),    32'd0);
        check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_req_ready", 32'(req_ready), 32'd1);
        wr_q.delete();
        rsp_q.delete();
        snap  = wr_seen;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("mid_rst_no_writes", 32'(wr_seen - snap), 32'd0);
        check_eq("mid_rst_no_rsp",    32'(rsp_valid),      32'd0);

        // Maximum operands, full-width product.
        send(8'hFF, 8'hFF, 8'h02, 1'b0);
        wait_rsp(lat);
        check_eq("max_data", 32'(rsp_data), 32'hFE01);
        @(posedge clk); #1;

        // Corrupted B readback, then a clean one.
        corrupt_b = 1'b1;
        send(8'h10, 8'h03, 8'h00, 1'b1);
        wait_rsp(lat);
        check_eq("rb_bad_latency", 32'(lat), 32'(EXP_LAT));
`ifdef ALU_BUS_MASTER_READBACK_EN
        check_eq("rb_bad_err", 32'(rsp_err), 32'd1);
`else
        check_eq("rb_off_err", 32'(rsp_err), 32'd0);
`endif
        @(posedge clk); #1;
        corrupt_b = 1'b0;
        send(8'h10, 8'h03, 8'h00, 1'b0);
        wait_rsp(lat);
        check_eq("rb_good_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("wr_q_drained",  32'(wr_q.size()),  32'd0);
        check_eq("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
